idu_issue_ctrl: RTL and testbench

- Decode-stage controller between IFU and EXU, for the RV64 core.
- Holds the IF->ID instruction register and runs valid/ready handshakes on both sides.
- Detects load-use hazards on the register sources of the held instruction and inserts bubbles.
- Squashes the held instruction on a redirect. The immediate generator and decoder read the held instruction it presents.

---
 rtl/idu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_idu_issue_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_issue_ctrl.sv
// Decode-stage issue controller: IF->ID instruction register, valid/ready on both sides,
// load-use bubble insertion and redirect squash. Optional counters under IDU_ISSUE_PERF_EN.
module idu_issue_ctrl #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [31:0]     NOP_INST = 32'h0000_0013,
  parameter logic [XLEN-1:0] PC_RST   = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid_i,
  input  logic [31:0]     if_inst_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            if_ready_o,
  output logic            id_valid_o,
  input  logic            ex_ready_i,
  output logic [31:0]     id_inst_o,
  output logic [XLEN-1:0] id_pc_o,
  input  logic            ex_load_valid_i,
  input  logic [4:0]      ex_load_rd_i,
  input  logic            flush_i,
  output logic            hazard_o
`ifdef IDU_ISSUE_PERF_EN
  ,
  output logic [63:0]     perf_issue_o,
  output logic [63:0]     perf_bubble_o
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_HAZ   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic held, rs1_use, rs2_use, rs1_hit, rs2_hit;
  logic hazard, id_valid, issue, if_ready, accept;

  always_comb begin
    rs1_use = 1'b0;
    rs2_use = 1'b0;
    case (inst_q[6:0])
      7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: begin
        rs1_use = 1'b1;
        rs2_use = 1'b1;
      end
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: rs1_use = 1'b1;
      default: ;
    endcase
  end

  assign held     = (state_q != S_EMPTY);
  assign rs1_hit  = rs1_use && (inst_q[19:15] == ex_load_rd_i);
  assign rs2_hit  = rs2_use && (inst_q[24:20] == ex_load_rd_i);
  // x0 is never a real load destination, so it can never stall an instruction.
  assign hazard   = held && ex_load_valid_i && (ex_load_rd_i != 5'd0) && (rs1_hit || rs2_hit);
  assign id_valid = held && !hazard && !flush_i;
  assign issue    = id_valid && ex_ready_i;
  assign if_ready = !rst && (!held || issue || flush_i);
  assign accept   = if_valid_i && if_ready;

  assign hazard_o   = hazard;
  assign id_valid_o = id_valid;
  assign if_ready_o = if_ready;
  assign id_inst_o  = inst_q;
  assign id_pc_o    = pc_q;

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    // A redirect outranks everything, including an instruction accepted this cycle.
    if (flush_i) begin
      state_d = S_EMPTY;
      inst_d  = NOP_INST;
    end else if (accept) begin
      state_d = S_FULL;
      inst_d  = if_inst_i;
      pc_d    = if_pc_i;
    end else if (issue) begin
      state_d = S_EMPTY;
      inst_d  = NOP_INST;
    end else if (held) begin
      state_d = hazard ? S_HAZ : S_FULL;
    end else begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      inst_q  <= NOP_INST;
      pc_q    <= PC_RST;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

`ifdef IDU_ISSUE_PERF_EN
  logic [63:0] perf_issue_q, perf_bubble_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_q  <= 64'd0;
      perf_bubble_q <= 64'd0;
    end else begin
      if (issue)  perf_issue_q  <= perf_issue_q + 64'd1;
      if (hazard) perf_bubble_q <= perf_bubble_q + 64'd1;
    end
  end

  assign perf_issue_o  = perf_issue_q;
  assign perf_bubble_o = perf_bubble_q;
`endif

endmodule

// File: tb/tb_idu_issue_ctrl.sv
// Bench for idu_issue_ctrl: directed vector table, hand-written reset/flush sequences,
// and randomized traffic checked against a queue-based behavioural model.
module tb_idu_issue_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid_i;
  logic [31:0] if_inst_i;
  logic [63:0] if_pc_i;
  logic        if_ready_o;
  logic        id_valid_o;
  logic        ex_ready_i;
  logic [31:0] id_inst_o;
  logic [63:0] id_pc_o;
  logic        ex_load_valid_i;
  logic [4:0]  ex_load_rd_i;
  logic        flush_i;
  logic        hazard_o;
`ifdef IDU_ISSUE_PERF_EN
  logic [63:0] perf_issue_o;
  logic [63:0] perf_bubble_o;
`endif

  idu_issue_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .if_valid_i      (if_valid_i),
    .if_inst_i       (if_inst_i),
    .if_pc_i         (if_pc_i),
    .if_ready_o      (if_ready_o),
    .id_valid_o      (id_valid_o),
    .ex_ready_i      (ex_ready_i),
    .id_inst_o       (id_inst_o),
    .id_pc_o         (id_pc_o),
    .ex_load_valid_i (ex_load_valid_i),
    .ex_load_rd_i    (ex_load_rd_i),
    .flush_i         (flush_i),
    .hazard_o        (hazard_o)
`ifdef IDU_ISSUE_PERF_EN
    ,
    .perf_issue_o    (perf_issue_o),
    .perf_bubble_o   (perf_bubble_o)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        vi;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        er;
    logic        lv;
    logic [4:0]  lrd;
    logic        fl;
    logic        e_rdy;
    logic        e_vld;
    logic        e_haz;
    logic [31:0] e_inst;
    logic [63:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  int checks = 0;
  int errors = 0;

  // Behavioural model: at most one held entry, plus the PC last presented.
  ent_t        held[$];
  logic [63:0] m_pc;
  logic [63:0] m_iss, m_bub;
  int          n_issued;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit uses_rs1(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011,
                          7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
  endfunction

  function automatic bit uses_rs2(input logic [31:0] i);
    return i[6:0] inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};
  endfunction

  task automatic drive(input vec_t v);
    if_valid_i      = v.vi;
    if_inst_i       = v.inst;
    if_pc_i         = v.pc;
    ex_ready_i      = v.er;
    ex_load_valid_i = v.lv;
    ex_load_rd_i    = v.lrd;
    flush_i         = v.fl;
  endtask

  // One clock: compare outputs at the negedge against the model (and optionally a
  // table row), then advance the model across the posedge.
  task automatic step(input bit use_tbl, input vec_t v, input string tag);
    bit          full, e_haz, e_vld, e_rdy, e_iss, e_acc;
    logic [31:0] hi;
    @(negedge clk);
    full  = (held.size() != 0);
    hi    = full ? held[0].inst : NOP;
    e_haz = full && ex_load_valid_i && (ex_load_rd_i != 0) &&
            ((uses_rs1(hi) && hi[19:15] == ex_load_rd_i) ||
             (uses_rs2(hi) && hi[24:20] == ex_load_rd_i));
    e_vld = full && !e_haz && !flush_i;
    e_iss = e_vld && ex_ready_i;
    e_rdy = !rst && (!full || e_iss || flush_i);
    e_acc = if_valid_i && e_rdy;
    chk({tag, ".hazard"},   {63'd0, hazard_o},   {63'd0, e_haz});
    chk({tag, ".id_valid"}, {63'd0, id_valid_o}, {63'd0, e_vld});
    chk({tag, ".if_ready"}, {63'd0, if_ready_o}, {63'd0, e_rdy});
    chk({tag, ".id_inst"},  {32'd0, id_inst_o},  {32'd0, hi});
    chk({tag, ".id_pc"},    id_pc_o,             m_pc);
`ifdef IDU_ISSUE_PERF_EN
    chk({tag, ".perf_issue"},  perf_issue_o,  m_iss);
    chk({tag, ".perf_bubble"}, perf_bubble_o, m_bub);
`endif
    if (use_tbl) begin
      chk({tag, ".tbl_hazard"},   {63'd0, hazard_o},   {63'd0, v.e_haz});
      chk({tag, ".tbl_id_valid"}, {63'd0, id_valid_o}, {63'd0, v.e_vld});
      chk({tag, ".tbl_if_ready"}, {63'd0, if_ready_o}, {63'd0, v.e_rdy});
      chk({tag, ".tbl_id_inst"},  {32'd0, id_inst_o},  {32'd0, v.e_inst});
      chk({tag, ".tbl_id_pc"},    id_pc_o,             v.e_pc);
    end
    @(posedge clk);
    if (rst) begin
      held.delete();
      m_pc  = 64'd0;
      m_iss = 64'd0;
      m_bub = 64'd0;
    end else begin
      if (e_iss) begin m_iss++; n_issued++; end
      if (e_haz) m_bub++;
      if (flush_i) held.delete();
      else if (e_acc) begin
        held.delete();
        held.push_back('{inst: if_inst_i, pc: if_pc_i});
        m_pc = if_pc_i;
      end else if (e_iss) held.delete();
    end
    #1;
  endtask

  task automatic addv(input logic vi, input logic [31:0] inst, input logic [63:0] pc,
                      input logic er, input logic lv, input logic [4:0] lrd, input logic fl,
                      input logic e_rdy, input logic e_vld, input logic e_haz,
                      input logic [31:0] e_inst, input logic [63:0] e_pc);
    vec_t v;
    v = '{vi, inst, pc, er, lv, lrd, fl, e_rdy, e_vld, e_haz, e_inst, e_pc};
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[12];
    logic [31:0] i;
    ops = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
    i        = $urandom;
    i[6:0]   = ops[$urandom_range(0, 11)];
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  localparam logic [63:0] P0 = 64'h8000_0000;

  initial begin
    vec_t idle;
    vec_t v;
    idle = '{1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 64'd0};
    n_issued = 0;
    m_iss = 0;
    m_bub = 0;
    m_pc  = 0;

    // Streaming
    addv(1, 32'h00100093, P0,      1, 0, 0, 0,  1, 0, 0, NOP,          64'd0);
    addv(1, 32'h00200113, P0 + 4,  1, 0, 0, 0,  1, 1, 0, 32'h00100093, P0);
    addv(1, 32'h00300193, P0 + 8,  1, 0, 0, 0,  1, 1, 0, 32'h00200113, P0 + 4);
    addv(0, 32'd0,        64'd0,   1, 0, 0, 0,  1, 1, 0, 32'h00300193, P0 + 8);
    // Back-pressure
    addv(1, 32'h00500093, 64'h100, 0, 0, 0, 0,  1, 0, 0, NOP,          P0 + 8);
    for (int k = 0; k < 4; k++)
      addv(1, 32'h00600113, 64'h104, 0, 0, 0, 0,  0, 1, 0, 32'h00500093, 64'h100);
    addv(1, 32'h00600113, 64'h104, 1, 0, 0, 0,  1, 1, 0, 32'h00500093, 64'h100);
    addv(0, 32'd0,        64'd0,   0, 0, 0, 0,  0, 1, 0, 32'h00600113, 64'h104);
    addv(0, 32'd0,        64'd0,   1, 0, 0, 0,  1, 1, 0, 32'h00600113, 64'h104);
    // Load-use on add x3,x1,x2
    addv(1, 32'h002081B3, 64'h108, 0, 0, 0, 0,  1, 0, 0, NOP,          64'h104);
    addv(0, 32'd0,        64'd0,   1, 1, 1, 0,  0, 0, 1, 32'h002081B3, 64'h108);
    addv(0, 32'd0,        64'd0,   1, 1, 1, 0,  0, 0, 1, 32'h002081B3, 64'h108);
    addv(0, 32'd0,        64'd0,   0, 0, 0, 0,  0, 1, 0, 32'h002081B3, 64'h108);
    addv(0, 32'd0,        64'd0,   0, 1, 5, 0,  0, 1, 0, 32'h002081B3, 64'h108);
    addv(0, 32'd0,        64'd0,   0, 1, 0, 0,  0, 1, 0, 32'h002081B3, 64'h108);
    addv(0, 32'd0,        64'd0,   1, 1, 2, 0,  0, 0, 1, 32'h002081B3, 64'h108);
    addv(0, 32'd0,        64'd0,   1, 0, 0, 0,  1, 1, 0, 32'h002081B3, 64'h108);
    // lui x1,0x12345: no sources, even when rd matches its rs1 field (8)
    addv(1, 32'h123450B7, 64'h10C, 0, 0, 0, 0,  1, 0, 0, NOP,          64'h108);
    addv(0, 32'd0,        64'd0,   0, 1, 0, 0,  0, 1, 0, 32'h123450B7, 64'h10C);
    addv(0, 32'd0,        64'd0,   1, 1, 8, 0,  1, 1, 0, 32'h123450B7, 64'h10C);
    // Flush with a simultaneous offer
    addv(1, 32'h00700193, 64'h110, 0, 0, 0, 0,  1, 0, 0, NOP,          64'h10C);
    addv(1, 32'h00800213, 64'h114, 1, 0, 0, 1,  1, 0, 0, 32'h00700193, 64'h110);
    addv(0, 32'd0,        64'd0,   1, 0, 0, 0,  1, 0, 0, NOP,          64'h110);
    addv(1, 32'h00900293, 64'h118, 1, 0, 0, 1,  1, 0, 0, NOP,          64'h110);
    addv(0, 32'd0,        64'd0,   1, 0, 0, 0,  1, 0, 0, NOP,          64'h110);

    // Reset then idle
    drive(idle);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, '{1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, NOP, 64'd0}, "reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      step(1'b1, vecs[i], $sformatf("vec%0d", i));
    end
`ifdef IDU_ISSUE_PERF_EN
    chk("tbl.perf_issue_total", perf_issue_o, 64'd7);
`endif
    chk("tbl.issued_total", 64'(n_issued), 64'd7);

    // Reset in the middle of a held instruction
    v = idle;
    v.vi = 1; v.inst = 32'h00A00313; v.pc = 64'h200;
    drive(v);
    step(1'b0, v, "mid_load");
    chk("mid.held_inst", {32'd0, id_inst_o}, 64'h00A00313);
    drive(idle);
    rst = 1'b1;
    step(1'b0, idle, "mid_rst");
    rst = 1'b0;
    chk("mid.inst_after_rst",  {32'd0, id_inst_o},  {32'd0, NOP});
    chk("mid.pc_after_rst",    id_pc_o,             64'd0);
    chk("mid.valid_after_rst", {63'd0, id_valid_o}, 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      v.vi   = ($urandom_range(0, 9) < 7);
      v.inst = rand_inst();
      v.pc   = {32'd0, $urandom} & ~64'h3;
      v.er   = ($urandom_range(0, 9) < 7);
      v.lv   = $urandom_range(0, 1);
      v.lrd  = 5'($urandom_range(0, 3));
      v.fl   = ($urandom_range(0, 9) == 0);
      drive(v);
      rst = ($urandom_range(0, 199) == 0);
      step(1'b0, v, "rand");
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
